// File: rtl/prog_sequence_detector_if.sv
// prog_sequence_detector_if: config, serial stream and status signals of the detector
interface prog_sequence_detector_if #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
   logic               cfg_we;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LEN_W-1:0]   cfg_len;
   logic               cfg_overlap;
   logic               in_valid;
   logic               in;
   logic               cnt_clr;
   logic               detected;
   logic [CNT_W-1:0]   match_count;
   logic               cfg_err;
   logic               armed;
   modport master (
      output cfg_we, cfg_pattern, cfg_len, cfg_overlap, in_valid, in, cnt_clr,
      input  detected, match_count, cfg_err, armed
   );
   modport slave (
      input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, in_valid, in, cnt_clr,
      output detected, match_count, cfg_err, armed
   );
endinterface

// File: rtl/prog_sequence_detector.sv
// prog_sequence_detector: runtime-programmable serial pattern detector with
// overlap control, registered match pulse and saturating match counter.
module prog_sequence_detector #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8
) (
   input logic clk,
   input logic reset,
   prog_sequence_detector_if.slave bus
);
   localparam int LEN_W = $clog2(MAX_LEN + 1);
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
   typedef enum logic {UNCFG, RUN} state_t;
   state_t             state_q, state_d;
   logic [MAX_LEN-1:0] pat_q, pat_d, hist_q, hist_d, hist_sh, mask;
   logic [LEN_W-1:0]   len_q, len_d, fill_q, fill_d, fill_inc;
   logic               ovl_q, ovl_d, det_q, det_d, err_q, err_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               cfg_ok, shift, match;
   always_comb begin
      cfg_ok   = bus.cfg_we && bus.cfg_len != '0 && bus.cfg_len <= LEN_MAX;
      shift    = state_q == RUN && bus.in_valid && !cfg_ok;
      hist_sh  = {hist_q[MAX_LEN-2:0], bus.in};
      fill_inc = fill_q == LEN_MAX ? fill_q : fill_q + 1'b1;
      // Bits of the pattern above len-1 are masked out of the compare.
      mask     = ~({MAX_LEN{1'b1}} << len_q);
      match    = shift && fill_inc >= len_q && ((hist_sh ^ pat_q) & mask) == '0;
      state_d  = cfg_ok ? RUN : state_q;
      pat_d    = cfg_ok ? bus.cfg_pattern : pat_q;
      len_d    = cfg_ok ? bus.cfg_len : len_q;
      ovl_d    = cfg_ok ? bus.cfg_overlap : ovl_q;
      hist_d   = cfg_ok ? '0 : shift ? hist_sh : hist_q;
      fill_d   = cfg_ok || (match && !ovl_q) ? '0 : shift ? fill_inc : fill_q;
      det_d    = match;
      err_d    = bus.cfg_we && !cfg_ok;
      cnt_d    = bus.cnt_clr ? CNT_W'(match) :
                 (match && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= UNCFG;
         pat_q   <= '0;
         len_q   <= '0;
         ovl_q   <= 1'b0;
         hist_q  <= '0;
         fill_q  <= '0;
         det_q   <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         ovl_q   <= ovl_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         det_q   <= det_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end
   assign bus.detected    = det_q;
   assign bus.match_count = cnt_q;
   assign bus.cfg_err     = err_q;
   assign bus.armed       = state_q == RUN;
endmodule

// File: doc/prog_sequence_detector.md
# prog_sequence_detector

Runtime-programmable serial bit-pattern detector. It replaces the fixed "101"/"110" detectors with one block. Pattern, length (1..MAX_LEN) and overlap mode are loaded at run time. It sits on a serial bit stream qualified by a valid strobe and emits a registered one-cycle match pulse plus a saturating match count for status readback.

## Interface
Parameters:
- MAX_LEN, 8, longest supported pattern in bits (2..32)
- CNT_W, 8, width of match counter (1..32)
- LEN_W, $clog2(MAX_LEN+1), width of length field (derived, not overridden)

Ports:
- clk  input  1  single clock, all logic on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- cfg_we  input  1  load cfg_pattern/cfg_len/cfg_overlap this cycle
- cfg_pattern  input  MAX_LEN  pattern; bit [cfg_len-1] is first bit on the wire, bit [0] last
- cfg_len  input  LEN_W  pattern length, legal 1..MAX_LEN
- cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping
- in_valid  input  1  qualifies in
- in  input  1  serial data bit
- cnt_clr  input  1  synchronous clear of match_count
- detected  output  1  one-cycle pulse per match
- match_count  output  CNT_W  saturating number of matches
- cfg_err  output  1  one-cycle pulse: rejected config write
- armed  output  1  block holds a valid configuration

## Operation
- FSM states: UNCFG (reset state, no valid pattern) and RUN.
- UNCFG:
  - in_valid ignored; detected stays 0.
  - A legal cfg_we moves the FSM to RUN.
- RUN:
  - Each in_valid bit shifts into history: hist <= {hist[MAX_LEN-2:0], in}.
  - fill increments, saturating at MAX_LEN.
- Match condition: (fill_next >= len) and hist_next[len-1:0] == pattern[len-1:0]. Both values are evaluated on the post-shift history.
- On a match:
  - detected pulses.
  - match_count increments unless it is all-ones, where it saturates.
  - Overlap = 1: fill is unchanged, so a suffix may begin the next match.
  - Overlap = 0: fill resets to 0, so the next match needs len fresh bits.
- Pattern bits above len-1 are don't-care.
- Config writes:
  - Legal write (1 <= cfg_len <= MAX_LEN), in either state: latch pattern, len and overlap, clear hist and fill, enter or stay in RUN. match_count is not affected.
  - Illegal cfg_len (0 or > MAX_LEN): the write is ignored, cfg_err pulses, and state and configuration are unchanged.
- Priority rules:
  - cfg_we with in_valid in the same cycle: the config wins, the bit is discarded, and no detection occurs.
  - cnt_clr with a match in the same cycle: match_count becomes 1.
  - cnt_clr alone: match_count becomes 0.
- armed = (state == RUN).

## Timing
- Reset values: detected=0, match_count=0, cfg_err=0, armed=0. Pattern, len, overlap, hist and fill are all 0. FSM is in UNCFG.
- Reset asserted mid-stream clears everything immediately (asynchronously). The block must be reconfigured afterwards.
- Latency:
  - detected is registered. If the completing bit is sampled at edge N, detected is high from edge N to edge N+1.
  - match_count updates at the same edge N.
- Throughput: one bit per cycle; in_valid may be held high continuously. Gaps in in_valid do not break partial matches.
- cfg_err is high for exactly the cycle after the offending write edge.
- A legal cfg_we at edge N: a bit sampled at N+1 is the first bit of the new history. armed rises at edge N.
- No combinational path from any input to any output.

## Test plan
- MAX_LEN=8: load pattern 3'b101, len 3, overlap=1; stream 1,0,1,0,1 -> detected on the 3rd and 5th bits; match_count=2.
- Same stream, overlap=0 -> detected on the 3rd bit only; match_count=1. Then stream 0,1 -> detected on the 7th bit; match_count=2.
- len=8, pattern 8'hA5; stream 0xA5 MSB-first with in_valid gaps of 1-3 cycles between bits -> single detected pulse one cycle after the 8th bit. A stream of 0xA4 gives no pulse.
- cfg_len=0, then cfg_len=9 while in RUN with pattern 101 -> cfg_err pulses twice and detection of 101 continues. In UNCFG, a stream of 1s gives detected=0 and armed=0.
- CNT_W=4, pattern len 1 = 1'b1, overlap=1; 20 consecutive 1s -> match_count saturates at 15. cnt_clr coincident with a match -> 1. cnt_clr alone -> 0.
- Assert reset mid-pattern (after 1,0 of 101) -> all outputs 0 and armed=0 immediately. After reset, a stream of 1 gives no detection until a legal cfg_we.
